// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit.
// Size codes, FSM states and the default data-segment base.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ST_WR,
        RMW_RD,
        RMW_WR,
        DONE
    } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane extraction for loads and lane merge for stores.
// Purely combinational; size 11 falls through to word behaviour.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    input  logic [31:0] wdata,
    output logic [31:0] loadVal,
    output logic [31:0] storeWord
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        byteLane  = word[{off, 3'b000} +: 8];
        halfLane  = off[1] ? word[31:16] : word[15:0];
        loadVal   = word;
        storeWord = wdata;
        case (size)
            SZ_BYTE: begin
                loadVal = {{24{~isUnsigned & byteLane[7]}}, byteLane};
                storeWord = word;
                storeWord[{off, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                loadVal = {{16{~isUnsigned & halfLane[15]}}, halfLane};
                storeWord = off[1] ? {wdata[15:0], word[15:0]}
                                   : {word[31:16], wdata[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between MEM stage and a word-addressed data memory.
// Sub-word stores are done as a read-modify-write of the whole word.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int          DM_ADDR_W = 11,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [DM_ADDR_W-1:0] dm_addr,
    output logic [31:0]          dm_writeData,
    output logic                 dm_memWrite,
    output logic                 dm_memRead,
    input  logic [31:0]          dm_readData
);

    localparam int OFF_W = DM_ADDR_W + 2;

    state_t state, stateNext;

    logic             wrReg;
    logic             unsReg;
    logic             errReg;
    logic [1:0]       sizeReg;
    logic [31:0]      wdataReg;
    logic [31:0]      mergeReg;
    logic [31:0]      rdataReg;
    logic [OFF_W-1:0] offReg;

    logic [31:0] reqOff;
    logic        reqErr;
    logic        accept;
    logic [31:0] alignWord;
    logic [31:0] loadVal;
    logic [31:0] storeWord;

    // Addresses below BASE wrap to huge offsets and hit the range check.
    assign reqOff = req_addr - BASE_ADDR;

    always_comb begin
        reqErr = (req_size == 2'b11)
              || (req_size == SZ_HALF && reqOff[0])
              || (req_size == SZ_WORD && reqOff[1:0] != 2'b00)
              || (reqOff[31:OFF_W] != '0);
    end

    assign accept    = req_valid && (state == IDLE);
    assign alignWord = (state == LOAD) ? dm_readData : mergeReg;

    mem_lane_align uAlign (
        .word       (alignWord),
        .off        (offReg[1:0]),
        .size       (sizeReg),
        .isUnsigned (unsReg),
        .wdata      (wdataReg),
        .loadVal    (loadVal),
        .storeWord  (storeWord)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext    = state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_err     = 1'b0;
        dm_memRead   = 1'b0;
        dm_memWrite  = 1'b0;
        dm_writeData = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (reqErr)                   stateNext = DONE;
                    else if (!req_write)          stateNext = LOAD;
                    else if (req_size == SZ_WORD) stateNext = ST_WR;
                    else                          stateNext = RMW_RD;
                end
            end
            LOAD: begin
                dm_memRead = 1'b1;
                stateNext  = DONE;
            end
            ST_WR: begin
                dm_memWrite  = 1'b1;
                dm_writeData = wdataReg;
                stateNext    = DONE;
            end
            RMW_RD: begin
                dm_memRead = 1'b1;
                stateNext  = RMW_WR;
            end
            RMW_WR: begin
                dm_memWrite  = 1'b1;
                dm_writeData = storeWord;
                stateNext    = DONE;
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = errReg;
                stateNext  = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrReg    <= 1'b0;
            unsReg   <= 1'b0;
            errReg   <= 1'b0;
            sizeReg  <= 2'b00;
            wdataReg <= '0;
            mergeReg <= '0;
            rdataReg <= '0;
            offReg   <= '0;
        end else begin
            if (accept) begin
                wrReg    <= req_write;
                unsReg   <= req_unsigned;
                errReg   <= reqErr;
                sizeReg  <= req_size;
                wdataReg <= req_wdata;
                offReg   <= reqOff[OFF_W-1:0];
            end
            if (state == LOAD)   rdataReg <= loadVal;
            if (state == RMW_RD) mergeReg <= dm_readData;
        end
    end

    assign resp_rdata = rdataReg;
    assign dm_addr    = offReg[OFF_W-1:2];

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-level reference memory model plus
// directed requests with literal expectations.
module tb_mem_access_unit;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [10:0] dm_addr;
    logic [31:0] dm_writeData;
    logic        dm_memWrite;
    logic        dm_memRead;
    logic [31:0] dm_readData;

    int passed = 0;
    int total  = 0;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dm_addr      (dm_addr),
        .dm_writeData (dm_writeData),
        .dm_memWrite  (dm_memWrite),
        .dm_memRead   (dm_memRead),
        .dm_readData  (dm_readData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory seen by the DUT
    logic [31:0] mem [2048];
    assign dm_readData = mem[dm_addr];

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = '0;
        forever begin
            @(posedge clk);
            if (dm_memWrite) mem[dm_addr] <= dm_writeData;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: byte-addressed memory and request queue
    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        int unsigned off;
        logic [31:0] wdata;
        int          age;
        int          nRd;
        int          nWr;
    } txn_t;

    txn_t        q[$];
    logic [7:0]  refMem [8192];
    logic [31:0] lastRdata;

    function automatic bit modelErr(txn_t t);
        return (t.sz == 2'd3) || (t.sz == 2'd1 && t.off % 2 != 0)
            || (t.sz == 2'd2 && t.off % 4 != 0) || (t.off >= 8192);
    endfunction

    function automatic logic [31:0] modelLoad(txn_t t);
        int n = 1 << t.sz;
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++)
            v |= 32'(refMem[t.off + i]) << (8 * i);
        if (!t.uns && n < 4 && v[8 * n - 1])
            v |= ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    function automatic logic [31:0] modelWord(txn_t t);
        int unsigned b = t.off & ~32'd3;
        int unsigned k = t.off - b;
        int n = 1 << t.sz;
        logic [31:0] w = '0;
        for (int j = 0; j < 4; j++) begin
            if (j >= k && j < k + n)
                w[8 * j +: 8] = t.wdata[8 * (j - k) +: 8];
            else if (b + j < 8192)
                w[8 * j +: 8] = refMem[b + j];
        end
        return w;
    endfunction

    task automatic applyStore(txn_t t);
        int n = 1 << t.sz;
        for (int i = 0; i < n; i++)
            refMem[t.off + i] = t.wdata[8 * i +: 8];
    endtask

    // Compare process: samples 2 time units after each falling edge
    initial begin
        txn_t t;
        bit   e;
        int   expLat, expRd, expWr;
        for (int i = 0; i < 8192; i++) refMem[i] = '0;
        lastRdata = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                q.delete();
                lastRdata = '0;
            end else begin
                if (resp_valid && q.size() == 0)
                    check("model spurious resp_valid", resp_valid, 0);
                if (q.size() > 0) begin
                    q[0].age++;
                    check("model busy req_ready", req_ready, 0);
                    check("model strobe excl", dm_memRead & dm_memWrite, 0);
                    if (dm_memRead) q[0].nRd++;
                    if (dm_memWrite) begin
                        q[0].nWr++;
                        check("model wr addr", dm_addr, q[0].off >> 2);
                        check("model wr data", dm_writeData, modelWord(q[0]));
                    end
                    if (resp_valid) begin
                        t = q.pop_front();
                        e = modelErr(t);
                        if (e) begin
                            expLat = 1; expRd = 0; expWr = 0;
                        end else if (!t.wr) begin
                            expLat = 2; expRd = 1; expWr = 0;
                            lastRdata = modelLoad(t);
                        end else if (t.sz == 2'd2) begin
                            expLat = 2; expRd = 0; expWr = 1;
                            applyStore(t);
                        end else begin
                            expLat = 3; expRd = 1; expWr = 1;
                            applyStore(t);
                        end
                        check("model resp_err", resp_err, e);
                        check("model resp_rdata", resp_rdata, lastRdata);
                        check("model latency", t.age, expLat);
                        check("model read cycles", t.nRd, expRd);
                        check("model write cycles", t.nWr, expWr);
                    end
                end
                if (req_valid && req_ready) begin
                    t.wr    = req_write;
                    t.sz    = req_size;
                    t.uns   = req_unsigned;
                    t.off   = req_addr - BASE;
                    t.wdata = req_wdata;
                    t.age   = 0;
                    t.nRd   = 0;
                    t.nWr   = 0;
                    q.push_back(t);
                end
            end
        end
    end

    task automatic doReq(input string name, input logic wr,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] expRdata, input logic expErr,
                         input int expLat);
        int n;
        @(negedge clk);
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 10);
        check({name, " rdata"}, resp_rdata, expRdata);
        check({name, " err"}, resp_err, expErr);
        check({name, " latency"}, n, expLat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int lowCnt;
        logic [31:0] lwData;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (2) @(negedge clk);
        check("reset req_ready", req_ready, 1);
        check("reset resp_valid", resp_valid, 0);
        check("reset resp_err", resp_err, 0);
        check("reset memRead", dm_memRead, 0);
        check("reset memWrite", dm_memWrite, 0);
        check("reset rdata", resp_rdata, 0);
        check("reset dm_addr", dm_addr, 0);
        check("reset writeData", dm_writeData, 0);
        rst = 1'b0;

        doReq("SW init", 1, 2'b10, 0, BASE + 32'h10, 32'h8899AABB, 32'h0, 0, 2);
        doReq("LB 11", 0, 2'b00, 0, BASE + 32'h11, 0, 32'hFFFFFFAA, 0, 2);
        doReq("LBU 11", 0, 2'b00, 1, BASE + 32'h11, 0, 32'h000000AA, 0, 2);
        doReq("LH 12", 0, 2'b01, 0, BASE + 32'h12, 0, 32'hFFFF8899, 0, 2);
        doReq("LHU 12", 0, 2'b01, 1, BASE + 32'h12, 0, 32'h00008899, 0, 2);
        doReq("LW 10", 0, 2'b10, 0, BASE + 32'h10, 0, 32'h8899AABB, 0, 2);
        doReq("SH 12", 1, 2'b01, 0, BASE + 32'h12, 32'h1234, 32'h8899AABB, 0, 3);
        doReq("LW after SH", 0, 2'b10, 0, BASE + 32'h10, 0, 32'h1234AABB, 0, 2);
        doReq("SB 13", 1, 2'b00, 0, BASE + 32'h13, 32'h5A, 32'h1234AABB, 0, 3);
        doReq("LW after SB", 0, 2'b10, 0, BASE + 32'h10, 0, 32'h5A34AABB, 0, 2);
        doReq("LB 10", 0, 2'b00, 0, BASE + 32'h10, 0, 32'hFFFFFFBB, 0, 2);
        doReq("LB top", 0, 2'b00, 0, BASE + 32'h1FFF, 0, 32'h0, 0, 2);
        doReq("err LW +2", 0, 2'b10, 0, BASE + 32'h2, 0, 32'h0, 1, 1);
        doReq("err SH +1", 1, 2'b01, 0, BASE + 32'h1, 32'hFFFF, 32'h0, 1, 1);
        doReq("err LW range", 0, 2'b10, 0, BASE + 32'h2000, 0, 32'h0, 1, 1);
        doReq("err LW below", 0, 2'b10, 0, BASE - 32'h4, 0, 32'h0, 1, 1);
        doReq("err size 11", 0, 2'b11, 0, BASE, 0, 32'h0, 1, 1);
        doReq("SW restore", 1, 2'b10, 0, BASE + 32'h10, 32'h8899AABB, 32'h0, 0, 2);

        // Reset while the sub-word store is reading
        @(negedge clk);
        req_write = 1'b1;
        req_size  = 2'b00;
        req_addr  = BASE + 32'h10;
        req_wdata = 32'hFF;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("rst-rmw in read", dm_memRead, 1);
        rst = 1'b1;
        #1;
        check("rst-rmw memWrite", dm_memWrite, 0);
        check("rst-rmw ready", req_ready, 1);
        repeat (2) begin
            @(negedge clk);
            check("rst-rmw memWrite held", dm_memWrite, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst-rmw ready after", req_ready, 1);
        check("rst-rmw mem word", mem[4], 32'h8899AABB);
        doReq("LW after rst", 0, 2'b10, 0, BASE + 32'h10, 0, 32'h8899AABB, 0, 2);

        // Back-to-back with req_valid held high
        @(negedge clk);
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = BASE + 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_write = 1'b0;
        cnt    = 0;
        lowCnt = 0;
        lwData = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i < 2 && !req_ready) lowCnt++;
            if (resp_valid) begin
                cnt++;
                lwData = resp_rdata;
            end
            if (req_ready && req_valid) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
            end
        end
        check("b2b ready low", lowCnt, 2);
        check("b2b resp count", cnt, 2);
        check("b2b LW data", lwData, 32'hCAFEF00D);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
